data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words in the backing array (power of two, 16..1024).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the cycles from request accept to response (legal 1..7).
REQ-003 The block SHALL have port clk, input, width 1, the single clock, with all state changing on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, width 1: the processor presents a load/store request.
REQ-006 The block SHALL have port req_ready, output, width 1: the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_we, input, width 1: 1 means store, 0 means load.
REQ-008 The block SHALL have port req_addr, input, width 32: byte address.
REQ-009 The block SHALL have port req_wdata, input, width 32: store data.
REQ-010 The block SHALL have port req_be, input, width 4: store byte enables, where bit i covers byte i (bits 8i+7:8i).
REQ-011 The block SHALL have port rsp_valid, output, width 1: a one-cycle response strobe.
REQ-012 The block SHALL have port rsp_rdata, output, width 32: load data, valid only while rsp_valid is high.
REQ-013 The block SHALL have port rsp_err, output, width 1: the request was misaligned or out of range, qualified by rsp_valid.
REQ-014 The block SHALL have port stall_out, output, width 1: the processor must hold its memory stage.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP, and SHALL assert req_ready only in IDLE.
REQ-016 A request SHALL be accepted at the rising edge where req_valid and req_ready are both 1, and SHALL latch we, addr, wdata and be.
REQ-017 On accept, the FSM SHALL go to RESP if LATENCY=1, else to WAIT with a 3-bit counter loaded with LATENCY-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter equals 1.
REQ-019 rsp_valid SHALL be high for exactly the one cycle spent in RESP, which is the LATENCY-th cycle after the accept edge; the FSM SHALL then return to IDLE unconditionally.
REQ-020 Only one transaction SHALL be outstanding at a time, giving a peak throughput of one request per LATENCY+1 cycles.
REQ-021 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-022 rsp_err SHALL be 1 if addr[1:0]!=0 or any address bit above the index is set.
REQ-023 On an error, no write SHALL occur and rsp_rdata SHALL be 0.
REQ-024 A store SHALL commit to the array on the edge entering RESP, writing only the bytes enabled by be; be=0000 SHALL perform no write and still respond.
REQ-025 A load's rsp_rdata SHALL be the full array word at the latched index; req_be SHALL be ignored for loads.
REQ-026 rsp_rdata SHALL be 0 whenever rsp_valid is 0, including for stores.
REQ-027 stall_out SHALL equal req_valid AND NOT (state==RESP), so the processor is held from presentation until the response cycle.
REQ-028 Request inputs SHALL be ignored outside IDLE; changing them mid-transaction SHALL have no effect.

Reset
REQ-029 While rst=0, the FSM SHALL be IDLE, the counter 0, latched request fields 0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-030 Assertion of rst SHALL abort any in-flight transaction, with no store committed and no response issued.
REQ-031 The array contents SHALL NOT be cleared by reset.
REQ-032 req_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-033 The FSM state encodings and the LATENCY bounds SHALL live in shared package mem_defs, together with the processor-side memory constants.
REQ-034 The byte-enabled synchronous-write array SHALL be a single sub-module, dmem_array, with ports clk, we, be, idx, wdata and rdata (combinational read).
REQ-035 The block SHALL contain no other sub-modules.

Verification
REQ-036 Store then load: with LATENCY=2, store addr=0x10, wdata=0xDEADBEEF, be=1111, accepted at edge 0, gives rsp_valid at cycle 2 with err=0; a load from 0x10 then returns rdata=0xDEADBEEF two cycles after its accept.
REQ-037 Partial store: with word 0x10=0xDEADBEEF, a store of wdata=0x11223344 with be=0101 makes a following load return 0xDE22BE44.
REQ-038 Errors: a load from 0x13 gives rsp_err=1 and rdata=0; a store to 0x400 (DEPTH_WORDS=256) gives rsp_err=1 and leaves word 0 unchanged.
REQ-039 Reset mid-WAIT: a store to 0x20 with rst pulsed low in cycle 1 gives no rsp_valid, word 0x20 unchanged, and req_ready=1 the cycle after release.
REQ-040 Back-to-back with LATENCY=1: req_valid held high over 4 loads gives accepts every 2 cycles, stall_out=1 in every non-RESP cycle, and rsp_valid pulses at cycles 1, 3, 5 and 7.
REQ-041 Latency sweep: for LATENCY=1..7, a single load shows exactly LATENCY cycles from accept to rsp_valid, with rsp_valid high for one cycle.

Source files
------------

// File: rtl/mem_defs_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, latency
// bounds and processor-side memory constants.
package mem_defs;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 7;
  localparam int CNT_W       = 3;

  localparam int XLEN       = 32;
  localparam int BYTE_LANES = XLEN / 8;
  localparam int DEPTH_MIN  = 16;
  localparam int DEPTH_MAX  = 1024;

  // Misaligned, or any byte-address bit above the word index is set.
  function automatic logic addrFault(input logic [XLEN-1:0] addr, input int idxBits);
    return (addr[1:0] != 2'b00) || ((addr >> (idxBits + 2)) != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word array: synchronous write per byte lane, combinational read.
module dmem_array
  import mem_defs::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata
);

  // One narrow array per lane keeps each byte write a plain full-width write.
  generate
    for (genvar gi = 0; gi < BYTE_LANES; gi++) begin : gLane
      logic [7:0] laneMem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          laneMem[idx] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = laneMem[idx];
    end
  endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with fixed request-to-response
// latency in front of a byte-enabled word array.
module data_mem_responder
  import mem_defs::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [BYTE_LANES-1:0] req_be,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic                  rsp_err,
  output logic                  stall_out
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [1:0]            stateReg, stateNext;
  logic [CNT_W-1:0]      cntReg, cntNext;
  logic                  weReg;
  logic [XLEN-1:0]       addrReg, wdataReg;
  logic [BYTE_LANES-1:0] beReg;

  logic                  accept, enterResp;
  logic                  selWe, selFault, rspFault;
  logic [XLEN-1:0]       selAddr, selWdata;
  logic [BYTE_LANES-1:0] selBe;
  logic [XLEN-1:0]       arrayRdata;

  assign req_ready = (stateReg == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign enterResp = (accept && (LATENCY == 1)) ||
                     ((stateReg == ST_WAIT) && (cntReg == CNT_W'(1)));

  // With LATENCY=1 the commit edge is the accept edge, so the array must see
  // the live request rather than the (not yet loaded) latched copy.
  assign selWe    = (stateReg == ST_IDLE) ? req_we    : weReg;
  assign selAddr  = (stateReg == ST_IDLE) ? req_addr  : addrReg;
  assign selWdata = (stateReg == ST_IDLE) ? req_wdata : wdataReg;
  assign selBe    = (stateReg == ST_IDLE) ? req_be    : beReg;
  assign selFault = addrFault(selAddr, IDX_W);
  assign rspFault = addrFault(addrReg, IDX_W);

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) uArray (
    .clk   (clk),
    .we    (enterResp && selWe && !selFault),
    .be    (selBe),
    .idx   (selAddr[IDX_W+1:2]),
    .wdata (selWdata),
    .rdata (arrayRdata)
  );

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            stateNext = ST_RESP;
          end else begin
            stateNext = ST_WAIT;
            cntNext   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        cntNext = cntReg - CNT_W'(1);
        if (cntReg == CNT_W'(1)) stateNext = ST_RESP;
      end
      ST_RESP: begin
        stateNext = ST_IDLE;
        cntNext   = '0;
      end
      default: begin
        stateNext = ST_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= ST_IDLE;
      cntReg   <= '0;
      weReg    <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      beReg    <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (accept) begin
        weReg    <= req_we;
        addrReg  <= req_addr;
        wdataReg <= req_wdata;
        beReg    <= req_be;
      end
    end
  end

  assign rsp_valid = (stateReg == ST_RESP);
  assign rsp_err   = rsp_valid && rspFault;
  assign rsp_rdata = (rsp_valid && !weReg && !rspFault) ? arrayRdata : '0;
  assign stall_out = req_valid && (stateReg != ST_RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: seven instances (LATENCY=1..7) share one
// stimulus stream and are checked every cycle against a transaction model.
module tb_data_mem_responder;

  localparam int NI = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqWe = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [3:0]  reqBe = '0;

  logic        readyV [NI];
  logic        rspValidV [NI];
  logic [31:0] rdataV [NI];
  logic        errV [NI];
  logic        stallV [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : gDut
      data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(gi + 1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_ready (readyV[gi]),
        .req_we    (reqWe),
        .req_addr  (reqAddr),
        .req_wdata (reqWdata),
        .req_be    (reqBe),
        .rsp_valid (rspValidV[gi]),
        .rsp_rdata (rdataV[gi]),
        .rsp_err   (errV[gi]),
        .stall_out (stallV[gi])
      );
    end
  endgenerate

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", name, inst, cyc, got, exp);
    end
  endtask

  function automatic bit tbFault(input bit [31:0] a);
    return ((a % 4) != 0) || (a >= 32'h400);
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd,
                                      input bit [3:0] be);
    bit [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Transaction model: busy from accept until the response cycle has passed.
  bit        mBusy [NI];
  bit        mRespNow [NI];
  int        mRespEdge [NI];
  bit        mWe [NI];
  bit [31:0] mAddr [NI];
  bit [31:0] mWdata [NI];
  bit [3:0]  mBe [NI];
  bit [31:0] mRdata [NI];
  bit        mErr [NI];
  bit        mRdKnown [NI];
  bit [31:0] mMem [NI][256];
  bit        mKnown [NI][256];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      automatic bit fire = 1'b0;
      automatic bit fWe = 1'b0;
      automatic bit [31:0] fAddr = '0;
      automatic bit [31:0] fWdata = '0;
      automatic bit [3:0] fBe = '0;
      automatic int w;
      if (!rst) begin
        mBusy[i]    <= 1'b0;
        mRespNow[i] <= 1'b0;
      end else if (mRespNow[i]) begin
        mRespNow[i] <= 1'b0;
        mBusy[i]    <= 1'b0;
      end else if (mBusy[i]) begin
        if (cyc == mRespEdge[i]) begin
          fire = 1'b1; fWe = mWe[i]; fAddr = mAddr[i]; fWdata = mWdata[i]; fBe = mBe[i];
        end
      end else if (reqValid) begin
        mBusy[i]     <= 1'b1;
        mWe[i]       <= reqWe;
        mAddr[i]     <= reqAddr;
        mWdata[i]    <= reqWdata;
        mBe[i]       <= reqBe;
        mRespEdge[i] <= cyc + i;
        if (i == 0) begin
          fire = 1'b1; fWe = reqWe; fAddr = reqAddr; fWdata = reqWdata; fBe = reqBe;
        end
      end
      if (fire) begin
        w = int'(fAddr[9:2]);
        mRespNow[i] <= 1'b1;
        mErr[i]     <= tbFault(fAddr);
        if (tbFault(fAddr) || fWe) begin
          mRdata[i]   <= '0;
          mRdKnown[i] <= 1'b1;
        end else begin
          mRdata[i]   <= mMem[i][w];
          mRdKnown[i] <= mKnown[i][w];
        end
        if (!tbFault(fAddr) && fWe && fBe != 4'b0000) begin
          mMem[i][w]   <= merge(mMem[i][w], fWdata, fBe);
          mKnown[i][w] <= mKnown[i][w] || (fBe == 4'b1111);
        end
      end
    end
  end

  // Per-cycle compare plus response recording for the directed checks.
  int        rspCnt [NI];
  int        rspCyc [NI];
  bit [31:0] lastRdata [NI];
  bit        lastErr [NI];
  int        pulses0 [$];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      automatic bit expValid = rst && mRespNow[i];
      chk("req_ready", i, 32'(readyV[i]), 32'(!rst || !mBusy[i]));
      chk("rsp_valid", i, 32'(rspValidV[i]), 32'(expValid));
      chk("rsp_err", i, 32'(errV[i]), 32'(expValid && mErr[i]));
      chk("stall_out", i, 32'(stallV[i]), 32'(reqValid && !expValid));
      if (!expValid || mRdKnown[i])
        chk("rsp_rdata", i, rdataV[i], expValid ? mRdata[i] : 32'h0);
      if (rspValidV[i]) begin
        rspCnt[i]++;
        rspCyc[i]    = cyc;
        lastRdata[i] = rdataV[i];
        lastErr[i]   = errV[i];
        if (i == 0) pulses0.push_back(cyc);
      end
    end
  end

  // One transaction presented for a single cycle; every instance accepts it.
  task automatic doOne(input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                       input bit [3:0] be, input bit [31:0] expRd, input bit expErr);
    int t0;
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < NI; i++) rspCnt[i] = 0;
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata; reqBe = be;
    @(posedge clk); #1;
    reqValid = 1'b0; reqWe = !we; reqAddr = $urandom; reqWdata = $urandom;
    reqBe = 4'($urandom);
    repeat (9) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("pulse_count", i, 32'(rspCnt[i]), 32'd1);
      chk("latency", i, 32'(rspCyc[i] - t0), 32'(i + 1));
    end
    chk("rdata", 1, lastRdata[1], expRd);
    chk("err", 1, 32'(lastErr[1]), 32'(expErr));
    $display("txn we=%0d addr=%h wdata=%h be=%b -> rdata=%h err=%0d", we, addr, wdata,
             be, lastRdata[1], lastErr[1]);
  endtask

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 1, 32'(readyV[1]), 32'd1);
    chk("reset_rdata", 1, rdataV[1], 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 1, 32'(readyV[1]), 32'd1);

    doOne(1'b1, 32'h0,   32'h0BADF00D, 4'b1111, 32'h0, 1'b0);
    doOne(1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
    doOne(1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);
    doOne(1'b1, 32'h10,  32'h11223344, 4'b0101, 32'h0, 1'b0);
    doOne(1'b0, 32'h10,  32'h0,        4'b1010, 32'hDE22BE44, 1'b0);
    doOne(1'b1, 32'h10,  32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    doOne(1'b0, 32'h10,  32'h0,        4'b0000, 32'hDE22BE44, 1'b0);
    doOne(1'b0, 32'h13,  32'h0,        4'b0000, 32'h0, 1'b1);
    doOne(1'b1, 32'h400, 32'h55555555, 4'b1111, 32'h0, 1'b1);
    doOne(1'b0, 32'h0,   32'h0,        4'b0000, 32'h0BADF00D, 1'b0);
    doOne(1'b0, 32'h10000000, 32'h0,   4'b0000, 32'h0, 1'b1);
    doOne(1'b1, 32'h20,  32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);

    // Reset pulsed while the store is in flight.
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) rspCnt[i] = 0;
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'h12345678; reqBe = 4'b1111;
    @(posedge clk); #1;
    reqValid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("ready_after_abort", i, 32'(readyV[i]), 32'd1);
    repeat (9) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk("aborted_no_rsp", i, 32'(rspCnt[i]), 32'd0);
    $display("txn reset-abort store addr=00000020");
    doOne(1'b0, 32'h20, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);
    chk("l1_commit_before_reset", 0, lastRdata[0], 32'h12345678);

    // Back-to-back loads with req_valid held high.
    @(posedge clk); #1;
    t0 = cyc;
    pulses0.delete();
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = 32'h10; reqBe = 4'b0000;
    repeat (8) @(posedge clk);
    #1;
    reqValid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_pulses", 0, 32'(pulses0.size()), 32'd4);
    for (int k = 0; k < pulses0.size() && k < 4; k++)
      chk("b2b_pulse_cycle", 0, 32'(pulses0[k] - t0), 32'(2 * k + 1));
    $display("txn back-to-back loads addr=00000010 pulses=%0d", pulses0.size());

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
